instr_fetch: RTL and testbench

//  Front end of the pipelined LEGv8 CPU: holds the program counter, drives the instruction-memory address and

---
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// LEGv8 fetch front end: PC register, instruction-memory address and IF/ID register.
// Taken branches redirect the PC from the ID-stage instruction and flush the wrong-path fetch.
module instr_fetch #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            BrTaken,
  input  logic            UncondBr,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            id_valid,
  output logic [10:0]     id_opcode,
  output logic [PC_W-1:0] br_target
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;
  logic [PC_W-1:0] imm_s;
  logic            taken;

  always_comb begin
    if (UncondBr) begin
      imm_s = {{(PC_W-26){id_instr_q[25]}}, id_instr_q[25:0]};
    end else begin
      imm_s = {{(PC_W-19){id_instr_q[23]}}, id_instr_q[23:5]};
    end
  end

  assign br_target = id_pc_q + (imm_s << 2);

  // A bubble in ID can never redirect the PC.
  assign taken = BrTaken & id_valid_q;

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d       = br_target;
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else begin
      pc_d       = pc_q + PC_W'(4);
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign id_opcode = id_instr_q[31:21];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic
// against a cycle-level reference model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, BrTaken, UncondBr;
  logic [63:0] imem_addr, id_pc, br_target;
  logic [31:0] imem_rdata, id_instr;
  logic        id_valid;
  logic [10:0] id_opcode;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem [logic [63:0]];
  logic [31:0] seed;

  logic [63:0] mpc, mpcid;
  logic [31:0] mins;
  logic        mval;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall),
    .BrTaken(BrTaken), .UncondBr(UncondBr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .id_opcode(id_opcode), .br_target(br_target)
  );

  function automatic logic [31:0] memrd(logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ seed;
  endfunction

  function automatic logic [63:0] tgt(logic [31:0] ins, logic [63:0] pc,
                                      logic u);
    longint imm;
    if (u) begin
      imm = longint'(ins[25:0]);
      if (imm >= 64'sd33554432) imm -= 64'sd67108864;
    end else begin
      imm = longint'(ins[23:5]);
      if (imm >= 64'sd262144) imm -= 64'sd524288;
    end
    return pc + 64'(imm * 4);
  endfunction

  task automatic step();
    logic [63:0] npc, nidpc;
    logic [31:0] nins;
    logic        nval;
    imem_rdata = memrd(imem_addr);
    npc = mpc; nidpc = mpcid; nins = mins; nval = mval;
    if (reset) begin
      npc = 64'h0; nidpc = 64'h0; nins = 32'h0; nval = 1'b0;
    end else if (stall) begin
      npc = mpc;
    end else if (BrTaken && mval) begin
      npc = tgt(mins, mpcid, UncondBr); nins = 32'h0; nval = 1'b0;
    end else begin
      nins = memrd(mpc); nidpc = mpc; npc = mpc + 64'd4; nval = 1'b1;
    end
    @(posedge clk);
    #1;
    mpc = npc; mpcid = nidpc; mins = nins; mval = nval;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp_a [3];
    exp_a = '{64'd4, 64'd8, 64'd12};
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    vecs++;
    if (imem_addr !== 64'h0 || id_valid !== 1'b0 || id_instr !== 32'h0) begin
      errs++;
      $display("FAIL reset: addr=%h valid=%b instr=%h want 0/0/0",
               imem_addr, id_valid, id_instr);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (imem_addr !== exp_a[i] || id_pc !== 64'(4 * i) || id_valid !== 1'b1
          || id_instr !== mins) begin
        errs++;
        $display("FAIL free_run%0d: addr=%h id_pc=%h valid=%b instr=%h want %h/%h/1/%h",
                 i, imem_addr, id_pc, id_valid, id_instr, exp_a[i], 64'(4 * i), mins);
      end
    end
  endtask

  task automatic test_taken_b();
    mem[64'h10] = 32'h14000003;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    BrTaken = 1'b1; UncondBr = 1'b1;
    #1;
    vecs++;
    if (id_pc !== 64'h10 || id_instr !== 32'h14000003 || br_target !== 64'h1C) begin
      errs++;
      $display("FAIL b_target: id_pc=%h instr=%h tgt=%h want 10/14000003/1c",
               id_pc, id_instr, br_target);
    end
    step();
    vecs++;
    if (imem_addr !== 64'h1C || id_valid !== 1'b0 || id_opcode !== 11'h0) begin
      errs++;
      $display("FAIL b_taken: addr=%h valid=%b opc=%h want 1c/0/0",
               imem_addr, id_valid, id_opcode);
    end
  endtask

  task automatic test_ignore_bubble();
    // continues from the flush left by test_taken_b, BrTaken still high
    step();
    vecs++;
    if (imem_addr !== 64'h20 || id_valid !== 1'b1 || id_pc !== 64'h1C) begin
      errs++;
      $display("FAIL bubble_br: addr=%h valid=%b id_pc=%h want 20/1/1c",
               imem_addr, id_valid, id_pc);
    end
    idle_inputs();
  endtask

  task automatic test_taken_cbz();
    int n;
    mem[64'h40] = 32'hB4FFFFC0;
    do_reset();
    n = 0;
    while (mpcid !== 64'h40 && n < 40) begin
      step();
      n++;
    end
    vecs++;
    if (id_pc !== 64'h40 || id_valid !== 1'b1) begin
      errs++;
      $display("FAIL cbz_reach: id_pc=%h valid=%b want 40/1", id_pc, id_valid);
    end
    BrTaken = 1'b1; UncondBr = 1'b0;
    step();
    vecs++;
    if (imem_addr !== 64'h38 || id_valid !== 1'b0 || id_instr !== 32'h0) begin
      errs++;
      $display("FAIL cbz_taken: addr=%h valid=%b instr=%h want 38/0/0",
               imem_addr, id_valid, id_instr);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    mem[64'h8] = 32'hB4000100;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    stall = 1'b1; BrTaken = 1'b1; UncondBr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (imem_addr !== 64'hC || id_pc !== 64'h8 || id_valid !== 1'b1
          || id_instr !== 32'hB4000100) begin
        errs++;
        $display("FAIL stall%0d: addr=%h id_pc=%h valid=%b instr=%h want c/8/1/b4000100",
                 i, imem_addr, id_pc, id_valid, id_instr);
      end
    end
    stall = 1'b0;
    step();
    vecs++;
    if (imem_addr !== 64'h28 || id_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_release: addr=%h valid=%b want 28/0", imem_addr, id_valid);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_precedence();
    mem[64'h10] = 32'h17FFFFFB;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    BrTaken = 1'b1; UncondBr = 1'b1;
    step();
    vecs++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || id_valid !== 1'b0) begin
      errs++;
      $display("FAIL neg_target: addr=%h valid=%b want fffffffffffffffc/0",
               imem_addr, id_valid);
    end
    BrTaken = 1'b0;
    step();
    vecs++;
    if (imem_addr !== 64'h0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_valid !== 1'b1) begin
      errs++;
      $display("FAIL pc_wrap: addr=%h id_pc=%h valid=%b want 0/fffffffffffffffc/1",
               imem_addr, id_pc, id_valid);
    end
    step();
    reset = 1'b1; stall = 1'b1; BrTaken = 1'b1;
    step();
    vecs++;
    if (imem_addr !== 64'h0 || id_valid !== 1'b0 || id_pc !== 64'h0) begin
      errs++;
      $display("FAIL reset_prio: addr=%h valid=%b id_pc=%h want 0/0/0",
               imem_addr, id_valid, id_pc);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    mem.delete();
    seed = $urandom;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      BrTaken  = ($urandom_range(0, 2) == 0);
      UncondBr = $urandom_range(0, 1) == 1;
      step();
      vecs++;
      if ({imem_addr, id_instr, id_pc, id_valid, id_opcode}
          !== {mpc, mins, mpcid, mval, mins[31:21]}) begin
        errs++;
        $display("FAIL rand%0d: addr=%h instr=%h id_pc=%h valid=%b want %h/%h/%h/%b",
                 i, imem_addr, id_instr, id_pc, id_valid, mpc, mins, mpcid, mval);
      end
      if (mval) begin
        vecs++;
        if (br_target !== tgt(mins, mpcid, UncondBr)) begin
          errs++;
          $display("FAIL rand_tgt%0d: tgt=%h want %h",
                   i, br_target, tgt(mins, mpcid, UncondBr));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    seed = 32'h5A5A1234;
    imem_rdata = 32'h0;
    mpc = 64'h0; mpcid = 64'h0; mins = 32'h0; mval = 1'b0;
    test_reset();
    test_taken_b();
    test_ignore_bubble();
    test_taken_cbz();
    test_stall();
    test_wrap_precedence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
